// File: rtl/hazard_control_unit_pkg.sv
// Shared constants for the hazard control unit: forwarding select encodings
// and the stall FSM state encoding.
package hazard_control_unit_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hcu_state_t;

endpackage

// File: rtl/hazard_control_unit_forward_select.sv
// One ALU operand forwarding mux select; EX/MEM has priority over MEM/WB,
// and register 0 never forwards.
module forward_select
    import hazard_control_unit_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic       exmem_reg_write_i,
    input  logic [4:0] exmem_write_register_i,
    input  logic       memwb_reg_write_i,
    input  logic [4:0] memwb_write_register_i,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REGFILE;
        if (exmem_reg_write_i && (exmem_write_register_i != 5'd0) &&
            (exmem_write_register_i == src_reg)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write_i && (memwb_write_register_i != 5'd0) &&
                     (memwb_write_register_i == src_reg)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: memory-wait freeze, redirect flush, load-use bubble,
// operand forwarding, saturating event counters and a sticky memory timeout.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs_i,
    input  logic [4:0]             id_rt_i,
    input  logic [4:0]             idex_rs_i,
    input  logic [4:0]             idex_rt_i,
    input  logic                   idex_mem_read_i,
    input  logic                   exmem_reg_write_i,
    input  logic [4:0]             exmem_write_register_i,
    input  logic                   memwb_reg_write_i,
    input  logic [4:0]             memwb_write_register_i,
    input  logic                   redirect_i,
    input  logic                   dmem_req_i,
    input  logic                   dmem_ready_i,
    output logic                   front_enable_o,
    output logic                   back_enable_o,
    output logic                   ifid_flush_o,
    output logic                   idex_flush_o,
    output logic [1:0]             forward_a_o,
    output logic [1:0]             forward_b_o,
    output logic [COUNT_WIDTH-1:0] load_stall_count_o,
    output logic [COUNT_WIDTH-1:0] flush_count_o,
    output logic                   mem_timeout_o,
    output logic                   state_o
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT_CYCLES);

    hcu_state_t state, state_next;
    logic [WW-1:0] wait_cnt;
    logic freeze, load_use, count_stall, count_flush;

    // dmem handshake: an access is outstanding while dmem_req_i is high and
    // completes in the cycle dmem_ready_i is also high; until then the whole
    // pipeline is frozen.
    assign freeze   = dmem_req_i & ~dmem_ready_i;
    assign load_use = idex_mem_read_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == id_rs_i) || (idex_rt_i == id_rt_i));

    always_comb begin
        state_next     = state;
        front_enable_o = 1'b1;
        back_enable_o  = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_flush_o   = 1'b0;
        count_stall    = 1'b0;
        count_flush    = 1'b0;
        case (state)
            ST_RUN:      if (freeze) state_next = ST_MEM_WAIT;
            ST_MEM_WAIT: if (!freeze) state_next = ST_RUN;
            default:     state_next = ST_RUN;
        endcase
        // The exit cycle of MEM_WAIT is handled by the RUN rules below.
        if (freeze) begin
            front_enable_o = 1'b0;
            back_enable_o  = 1'b0;
        end else if (redirect_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            count_flush  = 1'b1;
        end else if (load_use) begin
            front_enable_o = 1'b0;
            idex_flush_o   = 1'b1;
            count_stall    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= ST_RUN;
            wait_cnt           <= '0;
            mem_timeout_o      <= 1'b0;
            load_stall_count_o <= '0;
            flush_count_o      <= '0;
        end else begin
            state <= state_next;
            if (freeze) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WW'(1);
                if (wait_cnt >= WAIT_MAX - WW'(1)) mem_timeout_o <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (count_stall && (load_stall_count_o != '1))
                load_stall_count_o <= load_stall_count_o + COUNT_WIDTH'(1);
            if (count_flush && (flush_count_o != '1))
                flush_count_o <= flush_count_o + COUNT_WIDTH'(1);
        end
    end

    assign state_o = state;

    forward_select u_fwd_a (
        .src_reg                (idex_rs_i),
        .exmem_reg_write_i      (exmem_reg_write_i),
        .exmem_write_register_i (exmem_write_register_i),
        .memwb_reg_write_i      (memwb_reg_write_i),
        .memwb_write_register_i (memwb_write_register_i),
        .sel                    (forward_a_o)
    );

    forward_select u_fwd_b (
        .src_reg                (idex_rt_i),
        .exmem_reg_write_i      (exmem_reg_write_i),
        .exmem_write_register_i (exmem_write_register_i),
        .memwb_reg_write_i      (memwb_reg_write_i),
        .memwb_write_register_i (memwb_write_register_i),
        .sel                    (forward_b_o)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed scenarios plus random
// stimulus, checked against a rule-level reference model.
module tb_hazard_control_unit;

    localparam int CW   = 4;
    localparam int TO   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int EW   = 18;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs_i, id_rt_i, idex_rs_i, idex_rt_i;
    logic idex_mem_read_i, exmem_reg_write_i, memwb_reg_write_i;
    logic [4:0] exmem_write_register_i, memwb_write_register_i;
    logic redirect_i, dmem_req_i, dmem_ready_i;
    logic front_enable_o, back_enable_o, ifid_flush_o, idex_flush_o;
    logic [1:0] forward_a_o, forward_b_o;
    logic [CW-1:0] load_stall_count_o, flush_count_o;
    logic mem_timeout_o, state_o;

    hazard_control_unit #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .idex_rs_i(idex_rs_i), .idex_rt_i(idex_rt_i),
        .idex_mem_read_i(idex_mem_read_i),
        .exmem_reg_write_i(exmem_reg_write_i),
        .exmem_write_register_i(exmem_write_register_i),
        .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_write_register_i(memwb_write_register_i),
        .redirect_i(redirect_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .front_enable_o(front_enable_o), .back_enable_o(back_enable_o),
        .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
        .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
        .load_stall_count_o(load_stall_count_o), .flush_count_o(flush_count_o),
        .mem_timeout_o(mem_timeout_o), .state_o(state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_push = 0;
    int n_pop = 0;
    logic [EW-1:0] exp_q[$];

    // reference model: event tallies and the length of the current memory wait
    int  m_stall, m_flush, m_run;
    bit  m_timeout, m_waiting;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (exmem_reg_write_i && exmem_write_register_i != 0 && exmem_write_register_i == src)
            return 2'b10;
        if (memwb_reg_write_i && memwb_write_register_i != 0 && memwb_write_register_i == src)
            return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        m_stall = 0; m_flush = 0; m_run = 0; m_timeout = 0; m_waiting = 0;
    endtask

    // driver: apply one cycle of inputs, push the expected response, advance model
    task automatic step(input logic [4:0] irs, input logic [4:0] irt,
                        input logic [4:0] xrs, input logic [4:0] xrt, input logic mr,
                        input logic exw, input logic [4:0] exd,
                        input logic mww, input logic [4:0] mwd,
                        input logic redir, input logic req, input logic rdy);
        bit frz, lu;
        logic fe, be, f1, f2;
        @(posedge clk);
        #1;
        id_rs_i = irs; id_rt_i = irt; idex_rs_i = xrs; idex_rt_i = xrt;
        idex_mem_read_i = mr; exmem_reg_write_i = exw; exmem_write_register_i = exd;
        memwb_reg_write_i = mww; memwb_write_register_i = mwd;
        redirect_i = redir; dmem_req_i = req; dmem_ready_i = rdy;
        frz = req && !rdy;
        lu  = mr && xrt != 0 && (xrt == irs || xrt == irt);
        if (frz)        begin fe = 0; be = 0; f1 = 0; f2 = 0; end
        else if (redir) begin fe = 1; be = 1; f1 = 1; f2 = 1; end
        else if (lu)    begin fe = 0; be = 1; f1 = 0; f2 = 1; end
        else            begin fe = 1; be = 1; f1 = 0; f2 = 0; end
        exp_q.push_back({fe, be, f1, f2, model_fwd(xrs), model_fwd(xrt),
                         logic'(m_waiting), logic'(m_timeout),
                         CW'(m_stall), CW'(m_flush)});
        n_push++;
        if (!frz && redir && m_flush < CMAX) m_flush++;
        if (!frz && !redir && lu && m_stall < CMAX) m_stall++;
        if (frz) begin
            m_run++;
            if (m_run >= TO) m_timeout = 1;
        end else begin
            m_run = 0;
        end
        m_waiting = frz;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_step();
        step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), logic'($urandom_range(0, 9) == 0),
             logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 2) == 0));
    endtask

    // asynchronous reset mid-cycle, away from both clock edges
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_stall_cnt"}, int'(load_stall_count_o), 0);
        check({tag, "_flush_cnt"}, int'(flush_count_o), 0);
        check({tag, "_timeout"}, int'(mem_timeout_o), 0);
        check({tag, "_state_run"}, int'(state_o), 0);
        model_clear();
        id_rs_i = 0; id_rt_i = 0; idex_rs_i = 0; idex_rt_i = 0; idex_mem_read_i = 0;
        exmem_reg_write_i = 0; exmem_write_register_i = 0; memwb_reg_write_i = 0;
        memwb_write_register_i = 0; redirect_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            n_pop++;
            check("front_enable", int'(front_enable_o), int'(e[17]));
            check("back_enable", int'(back_enable_o), int'(e[16]));
            check("ifid_flush", int'(ifid_flush_o), int'(e[15]));
            check("idex_flush", int'(idex_flush_o), int'(e[14]));
            check("forward_a", int'(forward_a_o), int'(e[13:12]));
            check("forward_b", int'(forward_b_o), int'(e[11:10]));
            check("state", int'(state_o), int'(e[9]));
            check("mem_timeout", int'(mem_timeout_o), int'(e[8]));
            check("load_stall_count", int'(load_stall_count_o), int'(e[7:4]));
            check("flush_count", int'(flush_count_o), int'(e[3:0]));
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        model_clear();
        do_reset("por");
        idle();
        // load-use: one bubble, then the load has moved on
        step(8, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        step(8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // forwarding priority and register-0 exclusion
        step(0, 0, 5, 5, 0, 1, 5, 1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 3, 0, 0, 1, 0, 1, 3, 0, 0, 0);
        // redirect with a simultaneous load-use
        step(9, 2, 0, 9, 1, 0, 0, 0, 0, 1, 0, 0);
        idle();
        // three-cycle memory wait, then ready
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // six-cycle wait crosses the timeout; flag must stay sticky
        repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) idle();
        // reset in the middle of a wait
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        do_reset("mid_wait");
        idle();
        // flush counter saturation
        repeat (CMAX + 4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        do_reset("pre_rand");
        repeat (300) rand_step();
        do_reset("mid_rand");
        repeat (300) rand_step();
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("scoreboard_drained", n_pop, n_push);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
